// File: rtl/sreg_readout_packer.sv
// Buffers 42-bit readback words from the shift-register controller and
// serialises each one as a 6-byte, MSB-first frame onto a valid/ready byte stream.
module sreg_readout_packer #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    input  logic [41:0]               din,
    output logic                      m_valid,
    output logic [7:0]                m_data,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    input  logic                      clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL  = DEPTH[AW:0];
    localparam logic [AW:0] EMPTY_LVL = {(AW + 1){1'b0}};

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [41:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          overflow_r;

    logic [0:0]    state_r;
    logic [47:0]   hold_r;
    logic [2:0]    idx_r;
    logic          m_valid_r;
    logic [7:0]    m_data_r;
    logic          m_last_r;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          drop_s;
    logic          pop_s;
    logic          hs_s;
    logic [47:0]   head_s;

    // Byte k of a 48-bit frame, byte 0 being the most significant.
    function automatic logic [7:0] frame_byte(input logic [47:0] f, input logic [2:0] k);
        logic [7:0] b;
        case (k)
            3'd0:    b = f[47:40];
            3'd1:    b = f[39:32];
            3'd2:    b = f[31:24];
            3'd3:    b = f[23:16];
            3'd4:    b = f[15:8];
            3'd5:    b = f[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // FIFO status and push/pop decisions; fullness is judged before any same-cycle pop.
    always_comb begin
        full_s  = (level_r == FULL_LVL);
        empty_s = (level_r == EMPTY_LVL);
        push_s  = din_valid && !full_s;
        drop_s  = din_valid && full_s;
        hs_s    = m_valid_r && m_ready;
        head_s  = {6'b000000, mem_r[rd_ptr_r]};
        if (state_r == IDLE) begin
            pop_s = !empty_s;
        end else begin
            pop_s = hs_s && (idx_r == 3'd5) && !empty_s;
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= EMPTY_LVL;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + (AW + 1)'(1'b1);
                2'b01:   level_r <= level_r - (AW + 1)'(1'b1);
                default: level_r <= level_r;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_overflow) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Serialiser FSM driving the registered byte-stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            hold_r    <= 48'h0;
            idx_r     <= 3'd0;
            m_valid_r <= 1'b0;
            m_data_r  <= 8'h00;
            m_last_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        state_r   <= SEND;
                        hold_r    <= head_s;
                        idx_r     <= 3'd0;
                        m_valid_r <= 1'b1;
                        m_data_r  <= head_s[47:40];
                        m_last_r  <= 1'b0;
                    end
                end
                SEND: begin
                    if (hs_s) begin
                        if (idx_r != 3'd5) begin
                            idx_r    <= idx_r + 3'd1;
                            m_data_r <= frame_byte(hold_r, idx_r + 3'd1);
                            m_last_r <= (idx_r == 3'd4);
                        end else if (pop_s) begin
                            // Next frame follows byte5 with no idle cycle.
                            hold_r    <= head_s;
                            idx_r     <= 3'd0;
                            m_valid_r <= 1'b1;
                            m_data_r  <= head_s[47:40];
                            m_last_r  <= 1'b0;
                        end else begin
                            state_r   <= IDLE;
                            idx_r     <= 3'd0;
                            m_valid_r <= 1'b0;
                            m_data_r  <= 8'h00;
                            m_last_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    idx_r     <= 3'd0;
                    m_valid_r <= 1'b0;
                    m_data_r  <= 8'h00;
                    m_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign m_last   = m_last_r;
    assign level    = level_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_sreg_readout_packer.sv
// Randomised and directed bench for sreg_readout_packer against a queue-based
// model of the word FIFO and the outgoing byte stream.
module tb_sreg_readout_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic [41:0] din = 42'h0;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic        overflow;
    logic        clr_overflow = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int last_cnt = 0;

    logic [41:0] fifo_q[$];
    logic [7:0]  cur_q[$];
    logic [7:0]  got_q[$];
    logic        ov_m = 1'b0;

    logic [7:0] exp1 [6] = '{8'h02, 8'h6B, 8'h4B, 8'h5F, 8'h69, 8'h2B};
    localparam logic [41:0] WORD1 = 42'h2_6B4B_5F69_2B;

    sreg_readout_packer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .din_valid    (din_valid),
        .din          (din),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare outputs to the model, drive inputs, then advance the model.
    task automatic cyc(input logic dv, input logic [41:0] d, input logic rdy,
                       input logic clr, input logic r);
        logic        hs;
        logic        full;
        logic        pop;
        logic [41:0] w;
        logic [47:0] f;
        logic [7:0]  tmp;
        @(negedge clk);
        check("m_valid", {63'h0, m_valid}, {63'h0, cur_q.size() != 0});
        if (cur_q.size() != 0) begin
            check("m_data", {56'h0, m_data}, {56'h0, cur_q[0]});
            check("m_last", {63'h0, m_last}, {63'h0, cur_q.size() == 1});
        end else begin
            check("m_last_idle", {63'h0, m_last}, 64'h0);
        end
        check("level", 64'(level), 64'(fifo_q.size()));
        check("overflow", {63'h0, overflow}, {63'h0, ov_m});
        din_valid    = dv;
        din          = d;
        m_ready      = rdy;
        clr_overflow = clr;
        rst          = r;
        if (m_valid && rdy && !r) begin
            got_q.push_back(m_data);
            if (m_last) last_cnt++;
        end
        @(posedge clk);
        if (r) begin
            fifo_q.delete();
            cur_q.delete();
            ov_m = 1'b0;
        end else begin
            hs   = (cur_q.size() != 0) && rdy;
            full = (fifo_q.size() == DEPTH);
            pop  = (fifo_q.size() != 0) && ((cur_q.size() == 0) || (hs && cur_q.size() == 1));
            if (hs) tmp = cur_q.pop_front();
            if (pop) begin
                w = fifo_q.pop_front();
                for (int k = 0; k < 6; k++) begin
                    f = {6'b000000, w} >> (8 * (5 - k));
                    cur_q.push_back(f[7:0]);
                end
            end
            if (dv && !full) fifo_q.push_back(d);
            if (dv && full) ov_m = 1'b1;
            else if (clr) ov_m = 1'b0;
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 42'h0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] rnd;
        logic [41:0] w;
        logic        dv;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_data", {56'h0, m_data}, 64'h0);
        check("rst_m_valid", {63'h0, m_valid}, 64'h0);

        // Single word, fixed byte expectations.
        cyc(1'b0, 42'h0, 1'b1, 1'b0, 1'b0);
        got_q.delete();
        last_cnt = 0;
        cyc(1'b1, WORD1, 1'b1, 1'b0, 1'b0);
        idle(10, 1'b1);
        check("single_nbytes", 64'(got_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            check("single_byte", {56'h0, got_q[i]}, {56'h0, exp1[i]});
        check("single_lasts", 64'(last_cnt), 64'd1);

        // Back-to-back words.
        last_cnt = 0;
        cyc(1'b1, 42'h1_1234_5678_9A, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 42'h3_FEDC_BA98_76, 1'b1, 1'b0, 1'b0);
        idle(16, 1'b1);
        check("b2b_lasts", 64'(last_cnt), 64'd2);

        // Backpressure with ready pattern 1,0,0 repeating.
        got_q.delete();
        cyc(1'b1, WORD1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) cyc(1'b0, 42'h0, (i % 3) == 0, 1'b0, 1'b0);
        check("bp_nbytes", 64'(got_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            check("bp_byte", {56'h0, got_q[i]}, {56'h0, exp1[i]});

        // Overflow: six words with the stream stalled.
        last_cnt = 0;
        for (int i = 1; i <= 6; i++) cyc(1'b1, 42'(i * 42'h111), 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("ovf_set", {63'h0, overflow}, 64'h1);
        idle(40, 1'b1);
        check("ovf_frames", 64'(last_cnt), 64'd5);
        cyc(1'b0, 42'h0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 42'(i * 42'h3), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 42'h7, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        check("ovf_clr_vs_drop", {63'h0, overflow}, 64'h1);
        idle(40, 1'b1);
        cyc(1'b0, 42'h0, 1'b1, 1'b1, 1'b0);

        // Reset during byte2 with a second word queued.
        cyc(1'b1, 42'h2_AAAA_BBBB_CC, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 42'h1_DDDD_EEEE_FF, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        cyc(1'b0, 42'h0, 1'b1, 1'b0, 1'b1);
        got_q.delete();
        last_cnt = 0;
        cyc(1'b1, WORD1, 1'b1, 1'b0, 1'b0);
        idle(10, 1'b1);
        check("rst_frame_nbytes", 64'(got_q.size()), 64'd6);
        check("rst_frame_lasts", 64'(last_cnt), 64'd1);

        // Random traffic, backpressure, clears and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom(), $urandom()};
            w   = rnd[41:0];
            dv  = ($urandom_range(0, 99) < 45);
            cyc(dv, w, ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 5),
                ($urandom_range(0, 999) < 4));
        end
        idle(60, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sreg_readout_packer.md
# sreg_readout_packer

Downstream consumer of the shift-register controller's readback path. Captures each 42-bit word the controller presents on its read-data output (qualified by its data-valid strobe) and buffers it in a small FIFO. Each word is then serialised as a 6-byte frame onto a byte-wide valid/ready stream toward the host link. Decouples the controller's bursty PIX_READ / SREG_READ results from host backpressure and flags lost words.

## Interface

Parameters:
- DEPTH, 4, FIFO depth in 42-bit words; power of two, ≥ 2.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset: **synchronous and active-high**.
- din_valid  in  1  word strobe from sreg_ctrl (dvalid_out); one word per high cycle.
- din  in  42  readback word (sreg_ctrl data_out); sampled when din_valid=1.
- m_valid  out  1  byte stream valid.
- m_data  out  8  byte stream data.
- m_last  out  1  high on the final (6th) byte of a frame.
- m_ready  in  1  downstream accept.
- level  out  $clog2(DEPTH)+1  words held in the FIFO; excludes the word in the serialiser.
- overflow  out  1  sticky; set when a word is dropped.
- clr_overflow  in  1  clears overflow.

## Operation

- Frame format: word padded to 48 bits as {6'b0, din}, sent MSB byte first.
  - byte0 = {6'b0, din[41:40]}; byte1 = din[39:32]; … byte5 = din[7:0].
- FIFO:
  - Push when din_valid=1 and level<DEPTH.
  - Full is evaluated before any same-cycle pop. A push while level==DEPTH is dropped and overflow is set, even if a pop happens in the same cycle.
- Serialiser: 48-bit holding register plus byte index 0..5.
- FSM states:
  - IDLE: m_valid=0. If level>0, pop the head into the holding register, set index=0, go to SEND.
  - SEND: m_valid=1, m_data=byte[index], m_last=(index==5).
    - On m_valid&&m_ready with index<5: index+1.
    - On the handshake with index==5: if level>0, pop the next word, set index=0 and stay in SEND (no bubble). Otherwise go to IDLE.
- Hold rule: m_data and m_last stay stable while m_valid=1 and m_ready=0.
- Overflow:
  - Set on a dropped push; cleared by clr_overflow.
  - If set and clear occur in the same cycle, set wins.
- Pointers: wrap modulo DEPTH. level uses one extra bit so that full (level==DEPTH) is distinct from empty.
- Simultaneous push and pop with level<DEPTH: level unchanged, both take effect.

## Timing

- Reset values: m_valid=0, m_data=0, m_last=0, level=0, overflow=0, FSM=IDLE, pointers=0.
- Reset mid-frame discards the holding register and FIFO contents. No m_last is emitted for the abandoned frame.
- Latency (empty block):
  - din_valid high in cycle t → level=1 in cycle t+1.
  - Pop at the edge ending t+1 → m_valid=1 with byte0 in cycle t+2.
- Throughput: with m_ready held at 1, one byte per cycle. Back-to-back frames have zero idle cycles between byte5 of one frame and byte0 of the next.
- Output drive: m_valid, m_data and m_last are registered outputs.
- Pop effect: level decrements in the cycle after the pop edge.
- Signal updates: overflow and level update one cycle after the causing event.

## Test plan

- Single word: din=42'h2_6B4B_5F69_2B, m_ready=1 → m_valid rises 2 cycles later. Bytes are 02,6B,4B,5F,69,2B; m_last only on 2B; then m_valid=0 and level=0.
- Back-to-back: two words on consecutive cycles, m_ready=1 → 12 consecutive valid bytes with no gap. m_last is asserted exactly twice, on bytes 6 and 12.
- Backpressure: m_ready toggles 1,0,0,1,… during a frame → m_data is unchanged across every stalled cycle. The byte sequence is identical to the unstalled case.
- Overflow (DEPTH=4), m_ready=0, six words pushed on consecutive cycles:
  - Word1 moves into the serialiser; words 2–5 fill the FIFO (level=4); word6 is dropped and overflow=1.
  - After m_ready=1: exactly five frames (words 1–5) in order; overflow stays 1.
  - Then pulse clr_overflow → overflow=0. Repeat with clr_overflow coinciding with a drop → overflow stays 1.
- Reset mid-frame: assert rst during byte2 of a frame with a second word queued → next cycle m_valid=0, level=0, overflow=0. After release, a new word produces a clean 6-byte frame starting at byte0.
